// File: rtl/mem_port_arbiter_if.sv
// Core-side request strobes and memory-controller bus of mem_port_arbiter.
// The arbiter uses the slave view; the core/memory environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int W = 32
);
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_done;
    logic [W-1:0] if_rdata;
    logic         ld_req;
    logic [W-1:0] ld_addr;
    logic         ld_done;
    logic [W-1:0] ld_rdata;
    logic         st_req;
    logic [W-1:0] st_addr;
    logic [W-1:0] st_data;
    logic [3:0]   st_be;
    logic         st_done;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [3:0]   mem_be;
    logic [W-1:0] mem_rdata;
    logic         mem_ack;
    logic         timeout_err;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr,
        input  st_req, st_addr, st_data, st_be,
        input  mem_rdata, mem_ack,
        output if_done, if_rdata, ld_done, ld_rdata, st_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, timeout_err
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr,
        output st_req, st_addr, st_data, st_be,
        output mem_rdata, mem_ack,
        input  if_done, if_rdata, ld_done, ld_rdata, st_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch, load and store with data-over-fetch
// priority, a fetch anti-starvation limit and a mem_ack timeout watchdog.
module mem_port_arbiter #(
    parameter int W              = 32,
    parameter int TIMEOUT        = 64,
    parameter int DATA_BURST_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int WCW = $clog2(TIMEOUT);
    localparam int BCW = $clog2(DATA_BURST_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
    typedef enum logic [1:0] {G_IF, G_LD, G_ST} grant_e;

    state_e         state_q, state_d;
    grant_e         grant_q, grant_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [W-1:0]   mem_addr_q, mem_addr_d;
    logic [W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]     mem_be_q, mem_be_d;
    logic           if_done_q, if_done_d;
    logic           ld_done_q, ld_done_d;
    logic           st_done_q, st_done_d;
    logic           timeout_err_q, timeout_err_d;
    logic [W-1:0]   if_rdata_q, if_rdata_d;
    logic [W-1:0]   ld_rdata_q, ld_rdata_d;

    logic           any_req;
    logic           fetch_forced;
    logic           wait_last;
    logic [W-1:0]   resp_data;

    assign any_req      = bus.if_req | bus.ld_req | bus.st_req;
    assign fetch_forced = bus.if_req && (burst_cnt_q == BCW'(DATA_BURST_MAX));
    assign wait_last    = (wait_cnt_q == WCW'(TIMEOUT - 1));
    // An aborted read returns zero; an ack in the last wait cycle still wins.
    assign resp_data    = bus.mem_ack ? bus.mem_rdata : '0;

    always_comb begin
        // NOTE: every _d gets its hold/idle value first so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        wait_cnt_d    = wait_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        if_rdata_d    = if_rdata_q;
        ld_rdata_d    = ld_rdata_q;
        if_done_d     = 1'b0;
        ld_done_d     = 1'b0;
        st_done_d     = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (fetch_forced || !(bus.st_req || bus.ld_req)) grant_d = G_IF;
                    else if (bus.st_req)                             grant_d = G_ST;
                    else                                             grant_d = G_LD;

                    // Count data grants that made a waiting fetch step aside.
                    if (grant_d != G_IF && bus.if_req)
                        burst_cnt_d = fetch_forced ? burst_cnt_q : burst_cnt_q + 1'b1;
                    else
                        burst_cnt_d = '0;

                    mem_req_d  = 1'b1;
                    mem_we_d   = (grant_d == G_ST);
                    wait_cnt_d = '0;
                    state_d    = S_BUSY;
                    case (grant_d)
                        G_IF: begin
                            mem_addr_d = bus.if_addr;
                            mem_be_d   = 4'hF;
                        end
                        G_LD: begin
                            mem_addr_d = bus.ld_addr;
                            mem_be_d   = 4'hF;
                        end
                        G_ST: begin
                            mem_addr_d  = bus.st_addr;
                            mem_wdata_d = bus.st_data;
                            mem_be_d    = bus.st_be;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (bus.mem_ack || wait_last) begin
                    mem_req_d     = 1'b0;
                    timeout_err_d = !bus.mem_ack;
                    state_d       = S_RESP;
                    case (grant_q)
                        G_IF: begin
                            if_done_d  = 1'b1;
                            if_rdata_d = resp_data;
                        end
                        G_LD: begin
                            ld_done_d  = 1'b1;
                            ld_rdata_d = resp_data;
                        end
                        G_ST:    st_done_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: data/address registers are reset too, since every output must read 0 in reset.
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_q       <= G_IF;
            wait_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            if_done_q     <= 1'b0;
            ld_done_q     <= 1'b0;
            st_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            if_rdata_q    <= '0;
            ld_rdata_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q       <= state_d;
            grant_q       <= grant_d;
            wait_cnt_q    <= wait_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            if_done_q     <= if_done_d;
            ld_done_q     <= ld_done_d;
            st_done_q     <= st_done_d;
            timeout_err_q <= timeout_err_d;
            if_rdata_q    <= if_rdata_d;
            ld_rdata_q    <= ld_rdata_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.if_done     = if_done_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.st_done     = st_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ld_rdata    = ld_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;
    localparam int BURST   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.W(W)) bus ();

    mem_port_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .DATA_BURST_MAX(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: owner of the memory (-1 none, 0 fetch, 1 load, 2 store),
    // cycles it has waited, pending reply cycle, and data grants taken over a waiting fetch.
    int           m_owner, m_age, m_burst;
    bit           m_reply;
    int           grant_log[$];
    logic         e_mem_req, e_mem_we, e_if_done, e_ld_done, e_st_done, e_terr;
    logic [W-1:0] e_addr, e_wdata, e_if_rdata, e_ld_rdata;
    logic [3:0]   e_be;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_burst = 0; m_reply = 1'b0;
        e_mem_req = 0; e_mem_we = 0; e_if_done = 0; e_ld_done = 0; e_st_done = 0; e_terr = 0;
        e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_ld_rdata = '0; e_be = '0;
    endtask

    task automatic model_step();
        int           w;
        bit           acked;
        logic [W-1:0] d;
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        e_if_done = 0; e_ld_done = 0; e_st_done = 0; e_terr = 0;
        if (m_reply) begin
            m_reply = 1'b0;
        end else if (m_owner >= 0) begin
            acked = (bus.mem_ack === 1'b1);
            if (acked || m_age == TIMEOUT - 1) begin
                d         = acked ? bus.mem_rdata : '0;
                e_mem_req = 0;
                e_terr    = !acked;
                if (m_owner == 0) begin e_if_done = 1; e_if_rdata = d; end
                if (m_owner == 1) begin e_ld_done = 1; e_ld_rdata = d; end
                if (m_owner == 2) e_st_done = 1;
                m_owner = -1;
                m_reply = 1'b1;
            end else begin
                m_age++;
            end
        end else if (bus.if_req || bus.ld_req || bus.st_req) begin
            if (bus.if_req && m_burst >= BURST) w = 0;
            else if (bus.st_req)                w = 2;
            else if (bus.ld_req)                w = 1;
            else                                w = 0;
            m_burst = (w != 0 && bus.if_req) ? ((m_burst + 1 > BURST) ? BURST : m_burst + 1) : 0;
            m_owner = w;
            m_age   = 0;
            grant_log.push_back(w);
            e_mem_req = 1;
            e_mem_we  = (w == 2);
            e_be      = (w == 2) ? bus.st_be : 4'hF;
            e_addr    = (w == 0) ? bus.if_addr : (w == 1) ? bus.ld_addr : bus.st_addr;
            if (w == 2) e_wdata = bus.st_data;
        end
    endtask

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req",     bus.mem_req,     e_mem_req);
            check("mem_we",      bus.mem_we,      e_mem_we);
            check("mem_addr",    bus.mem_addr,    e_addr);
            check("mem_wdata",   bus.mem_wdata,   e_wdata);
            check("mem_be",      bus.mem_be,      e_be);
            check("if_done",     bus.if_done,     e_if_done);
            check("ld_done",     bus.ld_done,     e_ld_done);
            check("st_done",     bus.st_done,     e_st_done);
            check("timeout_err", bus.timeout_err, e_terr);
            check("if_rdata",    bus.if_rdata,    e_if_rdata);
            check("ld_rdata",    bus.ld_rdata,    e_ld_rdata);
        end
    end

    int           cyc = 0;
    bit           prev_req = 1'b0;
    logic [W-1:0] rise_addr[$];
    int           rise_cyc[$];

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (bus.mem_req === 1'b1 && !prev_req) begin
            rise_addr.push_back(bus.mem_addr);
            rise_cyc.push_back(cyc);
        end
        prev_req = (bus.mem_req === 1'b1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [W-1:0] starve_addr[10];
    int           starve_gnt[10];
    int           k, busy_cnt, ack_pct;

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.ld_req = 0; bus.ld_addr = '0;
        bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_be = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("reset mem_req", bus.mem_req, 0);
        check("reset dones", {bus.if_done, bus.ld_done, bus.st_done, bus.timeout_err}, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        idle_ticks(2);
        rst = 1'b1;
        idle_ticks(2);

        // Single fetch, ack in the second BUSY cycle.
        bus.if_addr = 32'h0000_0040; bus.if_req = 1;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                check("fetch mem_req", bus.mem_req, 1);
                check("fetch mem_we", bus.mem_we, 0);
                check("fetch mem_be", bus.mem_be, 4'hF);
                check("fetch mem_addr", bus.mem_addr, 32'h40);
            end
            bus.mem_ack = (i == 2); bus.mem_rdata = 32'h2408_0005;
            if (bus.if_done === 1'b1) begin k = i; break; end
        end
        check("fetch done latency", k, 3);
        check("fetch if_rdata", bus.if_rdata, 32'h2408_0005);
        bus.mem_ack = 0; bus.if_req = 0;
        tick();
        check("fetch done single pulse", bus.if_done, 0);
        idle_ticks(2);

        // Store with immediate ack.
        bus.st_addr = 32'h100; bus.st_data = 32'hDEAD_BEEF; bus.st_be = 4'b0011;
        bus.st_req = 1; bus.mem_ack = 1;
        tick();
        check("store mem_we", bus.mem_we, 1);
        check("store mem_be", bus.mem_be, 4'b0011);
        check("store mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("store st_done", bus.st_done, 1);
        check("store other dones", {bus.ld_done, bus.if_done}, 0);
        bus.st_req = 0; bus.mem_ack = 0;
        tick();
        check("store done single pulse", bus.st_done, 0);
        idle_ticks(2);

        // Simultaneous requests, each dropped on its done.
        rise_addr.delete(); rise_cyc.delete();
        bus.st_addr = 32'h3000; bus.ld_addr = 32'h2000; bus.if_addr = 32'h1000;
        bus.st_req = 1; bus.ld_req = 1; bus.if_req = 1; bus.mem_ack = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.st_done) bus.st_req = 0;
            if (bus.ld_done) bus.ld_req = 0;
            if (bus.if_done) bus.if_req = 0;
        end
        bus.mem_ack = 0;
        check("simul grant count", rise_addr.size(), 3);
        if (rise_addr.size() == 3) begin
            check("simul first is store", rise_addr[0], 32'h3000);
            check("simul second is load", rise_addr[1], 32'h2000);
            check("simul third is fetch", rise_addr[2], 32'h1000);
            check("simul gap 1", rise_cyc[1] - rise_cyc[0], 3);
            check("simul gap 2", rise_cyc[2] - rise_cyc[1], 3);
        end
        idle_ticks(2);

        // Fetch starvation limit with load and fetch held high.
        starve_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300,
                        32'h200, 32'h200, 32'h200, 32'h200, 32'h300};
        starve_gnt  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rise_addr.delete(); rise_cyc.delete(); grant_log.delete();
        bus.ld_addr = 32'h200; bus.if_addr = 32'h300; bus.mem_rdata = 32'hAAAA_5555;
        bus.ld_req = 1; bus.if_req = 1; bus.mem_ack = 1;
        idle_ticks(40);
        bus.ld_req = 0; bus.if_req = 0;
        idle_ticks(4);
        bus.mem_ack = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("starve dut grant %0d", i),
                  (i < rise_addr.size()) ? rise_addr[i] : 32'hFFFF_FFFF, starve_addr[i]);
            check($sformatf("starve model grant %0d", i),
                  (i < grant_log.size()) ? grant_log[i] : -1, starve_gnt[i]);
        end
        idle_ticks(2);

        // Watchdog abort on a load, then ack in the very last wait cycle.
        bus.ld_addr = 32'h400; bus.ld_req = 1; bus.mem_ack = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.mem_req) busy_cnt++;
            if (bus.ld_done) break;
        end
        check("timeout mem_req cycles", busy_cnt, 64);
        check("timeout err pulse", bus.timeout_err, 1);
        check("timeout ld_done", bus.ld_done, 1);
        check("timeout ld_rdata", bus.ld_rdata, 0);
        bus.ld_req = 0;
        tick();
        check("timeout err single pulse", bus.timeout_err, 0);
        idle_ticks(2);
        bus.ld_req = 1; bus.mem_rdata = 32'h1234_5678;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.mem_req) busy_cnt++;
            bus.mem_ack = (busy_cnt == 64 && bus.mem_req);
            if (bus.ld_done) break;
        end
        check("late ack mem_req cycles", busy_cnt, 64);
        check("late ack no error", bus.timeout_err, 0);
        check("late ack ld_done", bus.ld_done, 1);
        check("late ack ld_rdata", bus.ld_rdata, 32'h1234_5678);
        bus.ld_req = 0; bus.mem_ack = 0;
        idle_ticks(2);

        // Asynchronous reset in the middle of a BUSY access.
        bus.if_addr = 32'h500; bus.if_req = 1;
        idle_ticks(2);
        check("pre-reset mem_req", bus.mem_req, 1);
        #2;
        rst = 1'b0;
        model_reset();
        bus.if_req = 0;
        #1;
        check("async reset mem_req", bus.mem_req, 0);
        check("async reset dones", {bus.if_done, bus.ld_done, bus.st_done}, 0);
        idle_ticks(2);
        rst = 1'b1;
        bus.mem_ack = 1;
        tick();
        check("stale ack ignored", {bus.mem_req, bus.if_done, bus.ld_done, bus.st_done}, 0);
        bus.mem_ack = 0; bus.if_addr = 32'h600; bus.if_req = 1;
        idle_ticks(2);
        check("post-reset fetch busy", bus.mem_req, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
        tick();
        check("post-reset fetch done", bus.if_done, 1);
        check("post-reset if_rdata", bus.if_rdata, 32'hCAFE_0001);
        bus.if_req = 0; bus.mem_ack = 0;
        idle_ticks(2);

        // Randomized traffic; some windows never ack so the watchdog fires.
        ack_pct = 35;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ack_pct = ($urandom_range(3) == 0) ? 0 : 35;
            tick();
            if (e_if_done) bus.if_req = 0;
            if (e_ld_done) bus.ld_req = 0;
            if (e_st_done) bus.st_req = 0;
            if (m_owner == 0 && bus.if_req && $urandom_range(15) == 0) bus.if_req = 0;
            if (m_owner == 1 && bus.ld_req && $urandom_range(15) == 0) bus.ld_req = 0;
            if (m_owner == 2 && bus.st_req && $urandom_range(15) == 0) bus.st_req = 0;
            if (!bus.if_req && !e_if_done && m_owner != 0 && $urandom_range(3) == 0) begin
                bus.if_req = 1; bus.if_addr = $urandom;
            end
            if (!bus.ld_req && !e_ld_done && m_owner != 1 && $urandom_range(3) == 0) begin
                bus.ld_req = 1; bus.ld_addr = $urandom;
            end
            if (!bus.st_req && !e_st_done && m_owner != 2 && $urandom_range(4) == 0) begin
                bus.st_req = 1; bus.st_addr = $urandom; bus.st_data = $urandom;
                bus.st_be = 4'($urandom);
            end
            bus.mem_ack   = ($urandom_range(99) < ack_pct);
            bus.mem_rdata = $urandom;
        end
        bus.if_req = 0; bus.ld_req = 0; bus.st_req = 0; bus.mem_ack = 0;
        idle_ticks(TIMEOUT + 4);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
